// File: rtl/powlib_ip_pkg.sv
// powlib_ip_pkg: packet layout, op codes and pack/unpack helpers shared by powlib bus slaves.
package powlib_ip_pkg;

  localparam int POWLIB_BW     = 8;
  localparam int POWLIB_OPW    = 4;
  localparam int POWLIB_MAXDW  = 64;
  localparam int POWLIB_MAXBPD = 8;
  localparam int POWLIB_MAXWW  = POWLIB_MAXDW + POWLIB_MAXBPD + POWLIB_OPW;

  typedef enum logic [POWLIB_OPW-1:0] {
    POWLIB_OP_WRITE = 4'd0,
    POWLIB_OP_READ  = 4'd1
  } powlib_op_e;

  // Fields are held at their widest size so one helper serves every data width;
  // callers pass the real data width and bytes-per-word.
  typedef struct packed {
    logic [POWLIB_OPW-1:0]    op;
    logic [POWLIB_MAXBPD-1:0] be;
    logic [POWLIB_MAXDW-1:0]  data;
  } powlib_fields_t;

  // Builds a packet laid out LSB first as data, byte enables, op.
  function automatic logic [POWLIB_MAXWW-1:0] powlib_pack(input powlib_fields_t f,
                                                          input int dw, input int bpd);
    logic [POWLIB_MAXDW-1:0]  dataMask;
    logic [POWLIB_MAXBPD-1:0] beMask;
    dataMask = {POWLIB_MAXDW{1'b1}} >> (POWLIB_MAXDW - dw);
    beMask   = {POWLIB_MAXBPD{1'b1}} >> (POWLIB_MAXBPD - bpd);
    return POWLIB_MAXWW'(f.data & dataMask)
         | (POWLIB_MAXWW'(f.be & beMask) << dw)
         | (POWLIB_MAXWW'(f.op) << (dw + bpd));
  endfunction

  // Splits a packet back into its fields; unused upper field bits come back as zero.
  function automatic powlib_fields_t powlib_unpack(input logic [POWLIB_MAXWW-1:0] pkt,
                                                   input int dw, input int bpd);
    powlib_fields_t f;
    f.data = pkt[POWLIB_MAXDW-1:0] & ({POWLIB_MAXDW{1'b1}} >> (POWLIB_MAXDW - dw));
    f.be   = POWLIB_MAXBPD'(pkt >> dw) & ({POWLIB_MAXBPD{1'b1}} >> (POWLIB_MAXBPD - bpd));
    f.op   = POWLIB_OPW'(pkt >> (dw + bpd));
    return f;
  endfunction

endpackage

// File: rtl/ipram_outfifo.sv
// ipram_outfifo: 4-entry response FIFO with optional registered output stage.
// o_count covers every entry held, including the output register, so the
// parent can reserve space before issuing reads.
module ipram_outfifo
  import powlib_ip_pkg::*;
#(
  parameter int W   = 8,
  parameter bit EAR = 1'b1
)(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_data,
  input  logic         i_vld,
  output logic         o_rdy,
  output logic [W-1:0] o_data,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [2:0]   o_count
);

  localparam int DEPTH = 4;

  logic [W-1:0] r_buf [DEPTH];
  logic [1:0]   r_wPtr;
  logic [1:0]   r_rPtr;
  logic [2:0]   r_cnt;
  logic         w_push;
  logic         w_sPop;

  assign w_push = i_vld && o_rdy;
  assign o_rdy  = (r_cnt != 3'(DEPTH)) || w_sPop;

  // Pointer and occupancy bookkeeping; a push and pop together leave the count alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wPtr <= '0;
      r_rPtr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wPtr <= r_wPtr + 2'd1;
      if (w_sPop) r_rPtr <= r_rPtr + 2'd1;
      r_cnt <= r_cnt + 3'(w_push) - 3'(w_sPop);
    end
  end

  // Storage array; it needs no reset because occupancy says which slots are live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_buf[r_wPtr] <= i_data;
  end

  if (EAR) begin : g_ear
    logic         r_oVld;
    logic [W-1:0] r_oData;

    assign w_sPop  = (r_cnt != 3'd0) && (!r_oVld || i_rdy);
    assign o_vld   = r_oVld;
    assign o_data  = r_oData;
    assign o_count = r_cnt + 3'(r_oVld);

    // Output register refills from the head whenever it is empty or being taken,
    // and otherwise holds its contents steady for the consumer.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_oVld <= 1'b0;
      end else if (!r_oVld || i_rdy) begin
        r_oVld  <= (r_cnt != 3'd0);
        r_oData <= r_buf[r_rPtr];
      end
    end
  end else begin : g_direct
    assign w_sPop  = (r_cnt != 3'd0) && i_rdy;
    assign o_vld   = (r_cnt != 3'd0);
    assign o_data  = r_buf[r_rPtr];
    assign o_count = r_cnt;
  end

endmodule

// File: rtl/ipram.sv
// ipram: byte-enabled RAM slave on the powlib crossbar. WRITE packets update
// the RAM; READ packets come back as WRITE packets sent to the return address
// carried in the request data.
module ipram
  import powlib_ip_pkg::*;
#(
  parameter bit EAR    = 1'b1,
  parameter bit EDBG   = 1'b0,
  parameter int B_BASE = 0,
  parameter int B_SIZE = 'h4FFF,
  parameter int B_BPD  = 2,
  parameter int B_AW   = 16,
  localparam int B_DW  = POWLIB_BW * B_BPD,
  localparam int B_WW  = B_DW + B_BPD + POWLIB_OPW
)(
  input  logic            clk,
  input  logic            rst,
  input  logic [B_AW-1:0] wraddr,
  input  logic [B_WW-1:0] wrdata,
  input  logic            wrvld,
  output logic            wrrdy,
  output logic [B_AW-1:0] rdaddr,
  output logic [B_WW-1:0] rddata,
  output logic            rdvld,
  input  logic            rdrdy
);

  localparam int DEPTH = (B_SIZE + 1) / B_BPD;
  localparam int LGBPD = $clog2(B_BPD);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW    = B_AW + B_WW;

  powlib_fields_t          w_req;
  powlib_fields_t          w_rsp;
  logic [POWLIB_MAXWW-1:0] w_rspPkt;
  logic [31:0]             w_addr;
  logic [31:0]             w_off;
  logic                    w_inRange;
  logic                    w_accept;
  logic                    w_wr;
  logic                    w_rd;
  logic [IW-1:0]           w_index;
  logic [FW-1:0]           w_fifoIn;
  logic [FW-1:0]           w_fifoOut;
  logic                    w_fifoRdy;
  logic [2:0]              w_fifoCount;
  logic [3:0]              w_used;
  logic                    w_unused;

  logic [B_DW-1:0] r_mem [DEPTH];
  logic [B_DW-1:0] r_rdWord;
  logic [B_AW-1:0] r_rdRet;
  logic            r_rdVld;

  assign w_req     = powlib_unpack(POWLIB_MAXWW'(wrdata), B_DW, B_BPD);
  assign w_addr    = 32'(wraddr);
  assign w_off     = w_addr - 32'(B_BASE);
  assign w_inRange = (w_addr >= 32'(B_BASE)) && (w_off <= 32'(B_SIZE));
  assign w_index   = IW'(w_off >> LGBPD);
  assign w_accept  = wrvld && wrrdy;
  assign w_wr      = w_accept && w_inRange && (w_req.op == POWLIB_OP_WRITE);
  assign w_rd      = w_accept && w_inRange && (w_req.op == POWLIB_OP_READ);

  // Reads in flight plus everything held downstream may not exceed two when a new
  // request is taken, so the 4-entry FIFO can never overflow and never drops a response.
  assign w_used = 4'(w_fifoCount) + 4'(r_rdVld);
  assign wrrdy  = !rst && (w_used <= 4'd2);

  // RAM array with byte-enabled writes and a one-cycle synchronous read; it is not
  // reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int k = 0; k < B_BPD; k++) begin
        if (w_req.be[k]) r_mem[w_index][k*POWLIB_BW +: POWLIB_BW] <= w_req.data[k*POWLIB_BW +: POWLIB_BW];
      end
    end
    if (w_rd) r_rdWord <= r_mem[w_index];
  end

  // Marks a read whose word arrives from the RAM this cycle; reset discards it.
  always_ff @(posedge clk) begin
    if (rst) r_rdVld <= 1'b0;
    else     r_rdVld <= w_rd;
  end

  // Captures where the response has to be sent, alongside the RAM read.
  always_ff @(posedge clk) begin
    if (w_rd) r_rdRet <= w_req.data[B_AW-1:0];
  end

  // Response packet: the word read back, all bytes enabled, sent as a WRITE.
  always_comb begin
    w_rsp      = '0;
    w_rsp.data = POWLIB_MAXDW'(r_rdWord);
    w_rsp.be   = POWLIB_MAXBPD'({B_BPD{1'b1}});
    w_rsp.op   = POWLIB_OP_WRITE;
  end

  assign w_rspPkt = powlib_pack(w_rsp, B_DW, B_BPD);
  assign w_fifoIn = {r_rdRet, w_rspPkt[B_WW-1:0]};

  ipram_outfifo #(
    .W   (FW),
    .EAR (EAR)
  ) u_outfifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_data  (w_fifoIn),
    .i_vld   (r_rdVld),
    .o_rdy   (w_fifoRdy),
    .o_data  (w_fifoOut),
    .o_vld   (rdvld),
    .i_rdy   (rdrdy),
    .o_count (w_fifoCount)
  );

  assign rdaddr = w_fifoOut[FW-1:B_WW];
  assign rddata = w_fifoOut[B_WW-1:0];

  // The FIFO ready is always high thanks to the reservation above; EDBG only selects
  // simulation tracing, which is kept out of this synthesizable source.
  assign w_unused = ^{w_req, w_rspPkt, w_fifoRdy, EDBG};

endmodule

// File: tb/tb_ipram.sv
// tb_ipram: directed and randomized checks of ipram against a byte-addressed RAM model.
module tb_ipram;

  localparam int BASE = 'h5000;
  localparam int SIZE = 'h5FFF;
  localparam int BPD  = 2;
  localparam int AW   = 16;
  localparam int WW   = 22;
  localparam logic [3:0] OP_WRITE = 4'd0;
  localparam logic [3:0] OP_READ  = 4'd1;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic [AW-1:0] wraddr = '0;
  logic [WW-1:0] wrdata = '0;
  logic          wrvld  = 1'b0;
  logic          wrrdy;
  logic [AW-1:0] rdaddr;
  logic [WW-1:0] rddata;
  logic          rdvld;
  logic          rdrdy  = 1'b0;

  ipram #(
    .EAR    (1'b1),
    .EDBG   (1'b0),
    .B_BASE (BASE),
    .B_SIZE (SIZE),
    .B_BPD  (BPD),
    .B_AW   (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wraddr (wraddr),
    .wrdata (wrdata),
    .wrvld  (wrvld),
    .wrrdy  (wrrdy),
    .rdaddr (rdaddr),
    .rddata (rddata),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } rsp_t;

  rsp_t          expQ[$];
  rsp_t          monE;
  logic [7:0]    modelBytes [SIZE+1];
  int            testsRun    = 0;
  int            failures    = 0;
  int            acceptCount = 0;
  int            startAcc;
  logic          holdPending = 1'b0;
  logic [AW-1:0] heldAddr;
  logic [WW-1:0] heldData;
  logic [15:0]   poolAddr [16];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit owned(input logic [15:0] a);
    return (int'(a) >= BASE) && (int'(a) <= BASE + SIZE);
  endfunction

  // Model of one accepted request: byte-granular RAM plus an ordered list of responses.
  task automatic modelAccept(input logic [15:0] a, input logic [WW-1:0] pkt);
    int wordByte;
    logic [3:0] op;
    rsp_t r;
    op = pkt[21:18];
    if (!owned(a)) return;
    wordByte = ((int'(a) - BASE) / BPD) * BPD;
    if (op == OP_WRITE) begin
      for (int k = 0; k < BPD; k++)
        if (pkt[16+k]) modelBytes[wordByte+k] = pkt[8*k +: 8];
    end else if (op == OP_READ) begin
      r.addr = pkt[15:0];
      r.data = {modelBytes[wordByte+1], modelBytes[wordByte]};
      expQ.push_back(r);
    end
  endtask

  // Monitor sampling on the falling edge: checks response handshakes, the hold rule
  // under back-pressure, and feeds accepted requests to the model.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        checkOutput("holdVld", 64'(rdvld), 64'(1));
        checkOutput("holdAddr", 64'(rdaddr), 64'(heldAddr));
        checkOutput("holdData", 64'(rddata), 64'(heldData));
      end
      if (rdvld && rdrdy) begin
        checkOutput("rspPending", 64'(rdvld), 64'(expQ.size() != 0));
        if (expQ.size() != 0) begin
          monE = expQ.pop_front();
          checkOutput("rspAddr", 64'(rdaddr), 64'(monE.addr));
          checkOutput("rspData", 64'(rddata[15:0]), 64'(monE.data));
          checkOutput("rspBe", 64'(rddata[17:16]), 64'(2'b11));
          checkOutput("rspOp", 64'(rddata[21:18]), 64'(OP_WRITE));
        end
      end
      holdPending = rdvld && !rdrdy;
      heldAddr    = rdaddr;
      heldData    = rddata;
      if (wrvld && wrrdy) begin
        acceptCount++;
        modelAccept(wraddr, wrdata);
      end
    end
  end

  // Presents one request and holds it until accepted; returns just after the accept edge.
  task automatic applyStimulus(input logic [15:0] addr, input logic [3:0] op,
                               input logic [1:0] be, input logic [15:0] data);
    int n;
    n = 0;
    wraddr = addr;
    wrdata = {op, be, data};
    wrvld  = 1'b1;
    @(negedge clk);
    while (!wrrdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!wrrdy) checkOutput("acceptTimeout", 64'(wrrdy), 64'(1));
    @(posedge clk);
    #1;
    wrvld = 1'b0;
  endtask

  // Lets every outstanding response out and confirms nothing is left behind.
  task automatic waitDrain();
    int n;
    n = 0;
    rdrdy = 1'b1;
    while ((expQ.size() != 0 || rdvld) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drainLeft", 64'(expQ.size()), 64'(0));
    checkOutput("drainVld", 64'(rdvld), 64'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("rstVld", 64'(rdvld), 64'(0));
      checkOutput("rstRdy", 64'(wrrdy), 64'(0));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rdyAfterRst", 64'(wrrdy), 64'(1));
    checkOutput("noVldAfterRst", 64'(rdvld), 64'(0));
    @(posedge clk);
    #1;

    rdrdy = 1'b1;
    applyStimulus(16'h5000, OP_WRITE, 2'b11, 16'hBEEF);
    applyStimulus(16'h5000, OP_READ, 2'b11, 16'h0010);
    @(negedge clk);
    checkOutput("latency0", 64'(rdvld), 64'(0));
    @(negedge clk);
    checkOutput("latency1", 64'(rdvld), 64'(0));
    @(negedge clk);
    checkOutput("latency2", 64'(rdvld), 64'(1));
    waitDrain();

    applyStimulus(16'h5002, OP_WRITE, 2'b11, 16'h1234);
    applyStimulus(16'h5002, OP_WRITE, 2'b10, 16'hAB00);
    applyStimulus(16'h5002, OP_READ, 2'b11, 16'h0020);
    waitDrain();

    applyStimulus(16'hAFFE, OP_WRITE, 2'b11, 16'hF00D);
    applyStimulus(16'hAFFE, OP_READ, 2'b11, 16'h0030);
    applyStimulus(16'h5001, OP_WRITE, 2'b01, 16'h005A);
    applyStimulus(16'h5000, OP_READ, 2'b11, 16'h0034);
    waitDrain();
    applyStimulus(16'h4FFE, OP_READ, 2'b11, 16'h0040);
    applyStimulus(16'h5000, 4'd3, 2'b11, 16'h0044);
    applyStimulus(16'hB000, OP_READ, 2'b11, 16'h0048);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("noRspVld", 64'(rdvld), 64'(0));
    end
    @(posedge clk);
    #1;
    applyStimulus(16'h5000, OP_READ, 2'b11, 16'h004C);
    waitDrain();

    for (int i = 0; i < 6; i++)
      applyStimulus(16'(16'h5010 + 2*i), OP_WRITE, 2'b11, 16'(16'hC000 + 16'h111*i));
    rdrdy    = 1'b0;
    startAcc = acceptCount;
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyStimulus(16'(16'h5010 + 2*i), OP_READ, 2'b11, 16'(16'h0100 + i));
      end
      begin
        repeat (10) @(posedge clk);
        #2;
        checkOutput("bpAccepted", 64'(acceptCount - startAcc), 64'(3));
        checkOutput("bpStall", 64'(wrrdy), 64'(0));
        rdrdy = 1'b1;
      end
    join
    waitDrain();
    checkOutput("bpTotal", 64'(acceptCount - startAcc), 64'(6));

    applyStimulus(16'h5020, OP_WRITE, 2'b11, 16'h7E57);
    rdrdy = 1'b0;
    applyStimulus(16'h5020, OP_READ, 2'b11, 16'h0200);
    applyStimulus(16'h5010, OP_READ, 2'b11, 16'h0204);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("queuedVld", 64'(rdvld), 64'(1));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRstVld", 64'(rdvld), 64'(0));
    checkOutput("midRstRdy", 64'(wrrdy), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstRelease", 64'(wrrdy), 64'(1));
    @(posedge clk);
    #1;
    rdrdy = 1'b1;
    applyStimulus(16'h5020, OP_READ, 2'b11, 16'h0208);
    waitDrain();

    for (int i = 0; i < 8; i++) begin
      poolAddr[i]   = 16'(BASE + 2*i);
      poolAddr[i+8] = 16'(16'hAFF0 + 2*i);
    end
    for (int i = 0; i < 16; i++)
      applyStimulus(poolAddr[i], OP_WRITE, 2'b11, 16'($urandom));
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic [3:0]  op;
      int          p;
      if ($urandom_range(0, 9) < 8) a = poolAddr[$urandom_range(0, 15)] | 16'($urandom_range(0, 1));
      else begin
        case ($urandom_range(0, 3))
          0:       a = 16'h4FFE;
          1:       a = 16'h4FFF;
          2:       a = 16'hB000;
          default: a = 16'hFFFE;
        endcase
      end
      p = $urandom_range(0, 9);
      if (p < 4)      op = OP_WRITE;
      else if (p < 8) op = OP_READ;
      else            op = (p == 8) ? 4'd3 : 4'd15;
      rdrdy = ($urandom_range(0, 3) != 0) || !wrrdy;
      applyStimulus(a, op, 2'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
